// File: rtl/sync_debounce_edge_pkg.sv
// Shared definitions for the sync/debounce/edge-detect front end.
// Holds the debounce FSM state encoding and a constant clog2 helper so that
// later sequential blocks can reuse the same encodings.
package sync_debounce_edge_pkg;

  // Debounce FSM states: two settled levels and two counting states.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Constant ceiling log2; returns at least 1 so a counter is never zero-width.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_debounce_edge_sync_chain.sv
// sync_chain: STAGES-deep flop shift chain that brings an asynchronous bit
// into the clk domain. Asynchronous active-low reset clears every stage to 0.
// STAGES must be 2 or more.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input one stage further on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: synchronises a bouncy asynchronous input, debounces it
// with a consecutive-sample counter, and produces a clean level (q/qn),
// single-cycle rise/fall pulses and a stable flag. q feeds the d input of
// downstream register stages.
//
// Handshake: none; this block is a free-running conditioner. rise/fall are
// single-cycle strobes that accompany the cycle in which q changes and need
// no acknowledgement.
//
// Optional build macro SDE_EDGE_COUNT_EN adds edge_cnt[7:0], a saturating
// count of rise pulses.
//
// The FSM state and counter are kept in plainly named registers (state, cnt)
// so checkers can observe them directly.
module sync_debounce_edge
  import sync_debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_async,
  output logic       q,
  output logic       qn,
  output logic       rise,
  output logic       fall,
  output logic       stable
`ifdef SDE_EDGE_COUNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d_async),
    .q    (s)
  );

  // Debounce FSM: q flips only after DEBOUNCE_CYCLES consecutive samples that
  // differ from it; any agreeing sample in between restarts from idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= IDLE_HIGH;
              q     <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= WAIT_HIGH;
              cnt   <= CNT_ONE;
            end
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            q     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= IDLE_LOW;
              q     <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= WAIT_LOW;
              cnt   <= CNT_ONE;
            end
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            q     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // qn follows q combinationally so it is 1 throughout reset.
  assign qn = ~q;

  // Settled whenever the FSM is not counting a candidate change.
  assign stable = (state == IDLE_LOW) || (state == IDLE_HIGH);

`ifdef SDE_EDGE_COUNT_EN
  // Count rise pulses, holding at 255 once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 8'd0;
    end else if (rise && (edge_cnt != 8'hFF)) begin
      edge_cnt <= edge_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Testbench for sync_debounce_edge. A behavioural model keeps the history of
// sampled inputs and applies the debounce rule directly: q flips when the
// last DEBOUNCE_CYCLES synchronised samples all differ from q.
// Define SDE_EDGE_COUNT_EN to also exercise edge_cnt.
module tb_sync_debounce_edge;

  localparam int S = 2;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  logic d_async;
  logic q;
  logic qn;
  logic rise;
  logic fall;
  logic stable;
`ifdef SDE_EDGE_COUNT_EN
  logic [7:0] edge_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit d_hist[$];
  bit s_hist[$];
  bit q_m;
  bit rise_m;
  bit fall_m;
  bit stable_m;
  int run_m;
  int edge_m;

  sync_debounce_edge #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_async(d_async),
    .q      (q),
    .qn     (qn),
    .rise   (rise),
    .fall   (fall),
    .stable (stable)
`ifdef SDE_EDGE_COUNT_EN
    ,
    .edge_cnt(edge_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the synchroniser shows the input sampled S edges
  // earlier; q toggles once D consecutive such samples disagree with it.
  always @(posedge clk or negedge rst_n) begin : model
    bit s;
    bit all_diff;
    if (!rst_n) begin
      d_hist.delete();
      s_hist.delete();
      q_m      = 1'b0;
      rise_m   = 1'b0;
      fall_m   = 1'b0;
      stable_m = 1'b1;
      run_m    = 0;
      edge_m   = 0;
    end else begin
      if (rise_m && edge_m < 255) edge_m++;
      d_hist.push_back(d_async);
      if (d_hist.size() > 16) void'(d_hist.pop_front());
      s = (d_hist.size() > S) ? d_hist[d_hist.size() - 1 - S] : 1'b0;
      s_hist.push_back(s);
      if (s_hist.size() > 16) void'(s_hist.pop_front());
      rise_m = 1'b0;
      fall_m = 1'b0;
      all_diff = (s_hist.size() >= D);
      for (int i = 0; i < D && all_diff; i++)
        if (s_hist[s_hist.size() - 1 - i] == q_m) all_diff = 1'b0;
      if (all_diff) begin
        q_m    = !q_m;
        rise_m = q_m;
        fall_m = !q_m;
      end
      run_m = 0;
      for (int i = s_hist.size() - 1; i >= 0 && s_hist[i] != q_m; i--) run_m++;
      stable_m = (run_m == 0);
    end
  end

  task automatic test_reset();
    int rise_at;
    logic [4:0] obs, expv;
    rst_n   = 1'b0;
    d_async = 1'b1;
    #1;
    checks++;
    if ({q, qn, rise, fall, stable} !== 5'b01001) begin
      errors++;
      $display("FAIL reset_values: got q/qn/rise/fall/stable=%b want 01001", {q, qn, rise, fall, stable});
    end
    #11;
    rst_n   = 1'b1;
    rise_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      obs  = {q, qn, rise, fall, stable};
      expv = {q_m, !q_m, rise_m, fall_m, stable_m};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_release_cycle%0d: got %b want %b", i, obs, expv);
      end
      if (rise === 1'b1 && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != S + D - 1) begin
      errors++;
      $display("FAIL reset_release_latency: got rise at edge k+%0d want k+%0d", rise_at, S + D - 1);
    end
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_q: got %b want 1", q);
    end
  endtask

  task automatic test_clean_fall();
    int fall_at;
    int falls;
    logic [4:0] obs, expv;
    @(negedge clk);
    d_async = 1'b0;
    fall_at = -1;
    falls   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      obs  = {q, qn, rise, fall, stable};
      expv = {q_m, !q_m, rise_m, fall_m, stable_m};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL clean_fall_cycle%0d: got %b want %b", i, obs, expv);
      end
      if (fall === 1'b1) begin
        falls++;
        if (fall_at < 0) fall_at = i;
      end
    end
    checks++;
    if (falls != 1 || fall_at != S + D - 1) begin
      errors++;
      $display("FAIL clean_fall_pulse: got %0d pulses at k+%0d want 1 at k+%0d", falls, fall_at, S + D - 1);
    end
    checks++;
    if ({q, qn} !== 2'b01) begin
      errors++;
      $display("FAIL clean_fall_level: got q/qn=%b want 01", {q, qn});
    end
  endtask

  task automatic test_clean_rise();
    int rises;
    int falls;
    int unstable;
    logic [4:0] obs, expv;
    @(negedge clk);
    d_async  = 1'b1;
    rises    = 0;
    falls    = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs  = {q, qn, rise, fall, stable};
      expv = {q_m, !q_m, rise_m, fall_m, stable_m};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL clean_rise_cycle%0d: got %b want %b", i, obs, expv);
      end
      if (rise === 1'b1) rises++;
      if (fall === 1'b1) falls++;
      if (stable === 1'b0) unstable++;
    end
    checks++;
    if (rises != 1 || falls != 0) begin
      errors++;
      $display("FAIL clean_rise_pulses: got rise=%0d fall=%0d want 1 and 0", rises, falls);
    end
    checks++;
    if (unstable != D - 1) begin
      errors++;
      $display("FAIL clean_rise_stable_low: got %0d cycles want %0d", unstable, D - 1);
    end
    checks++;
    if ({q, qn} !== 2'b10) begin
      errors++;
      $display("FAIL clean_rise_level: got q/qn=%b want 10", {q, qn});
    end
  endtask

  task automatic test_glitch();
    int rises;
    logic [4:0] obs, expv;
    @(negedge clk);
    d_async = 1'b0;
    repeat (S + D + 2) @(negedge clk);
    d_async = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d_async = 1'b0;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs  = {q, qn, rise, fall, stable};
      expv = {q_m, !q_m, rise_m, fall_m, stable_m};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL glitch_cycle%0d: got %b want %b", i, obs, expv);
      end
      if (rise === 1'b1) rises++;
    end
    checks++;
    if (q !== 1'b0 || rises != 0 || stable !== 1'b1) begin
      errors++;
      $display("FAIL glitch_reject: got q=%b rises=%0d stable=%b want 0 0 1", q, rises, stable);
    end
    checks++;
    if (dut.cnt !== '0) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d want 0", dut.cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    int rise_at;
    logic [4:0] obs, expv;
    @(negedge clk);
    d_async = 1'b1;
    guard   = 0;
    while (run_m != 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (run_m != 3 || int'(dut.cnt) != 3) begin
      errors++;
      $display("FAIL mid_wait_reach: got cnt=%0d want 3 within 20 cycles", dut.cnt);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q, qn, rise, fall, stable} !== 5'b01001 || dut.cnt !== '0) begin
      errors++;
      $display("FAIL mid_wait_reset: got q/qn/rise/fall/stable=%b cnt=%0d want 01001 cnt=0",
               {q, qn, rise, fall, stable}, dut.cnt);
    end
    #1;
    rst_n   = 1'b1;
    rise_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs  = {q, qn, rise, fall, stable};
      expv = {q_m, !q_m, rise_m, fall_m, stable_m};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL mid_wait_release_cycle%0d: got %b want %b", i, obs, expv);
      end
      if (rise === 1'b1 && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != S + D - 1) begin
      errors++;
      $display("FAIL mid_wait_latency: got rise at k+%0d want k+%0d", rise_at, S + D - 1);
    end
  endtask

  task automatic test_random();
    int hold;
    logic [4:0] obs, expv;
    for (int seg = 0; seg < 80; seg++) begin
      @(negedge clk);
      d_async = 1'($urandom_range(0, 1));
      hold    = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        if (c > 0) @(negedge clk);
        obs  = {q, qn, rise, fall, stable};
        expv = {q_m, !q_m, rise_m, fall_m, stable_m};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random_seg%0d_c%0d: got %b want %b", seg, c, obs, expv);
        end
        checks++;
        if ((rise & fall) !== 1'b0 || int'(dut.cnt) != run_m || int'(dut.cnt) > D - 1) begin
          errors++;
          $display("FAIL random_cnt_seg%0d_c%0d: got rise=%b fall=%b cnt=%0d want no overlap cnt=%0d",
                   seg, c, rise, fall, dut.cnt, run_m);
        end
      end
    end
  endtask

`ifdef SDE_EDGE_COUNT_EN
  task automatic test_edge_count();
    @(negedge clk);
    d_async = 1'b0;
    rst_n   = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      d_async = 1'b1;
      repeat (S + D + 2) @(negedge clk);
      d_async = 1'b0;
      repeat (S + D + 2) @(negedge clk);
    end
    checks++;
    if (edge_cnt !== 8'(edge_m) || edge_cnt !== 8'd3) begin
      errors++;
      $display("FAIL edge_cnt_three: got %0d want %0d (3)", edge_cnt, edge_m);
    end
    for (int p = 0; p < 257; p++) begin
      d_async = 1'b1;
      repeat (S + D + 2) @(negedge clk);
      d_async = 1'b0;
      repeat (S + D + 2) @(negedge clk);
    end
    checks++;
    if (edge_cnt !== 8'(edge_m) || edge_cnt !== 8'd255) begin
      errors++;
      $display("FAIL edge_cnt_saturate: got %0d want %0d (255)", edge_cnt, edge_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_glitch();
    test_reset_mid_wait();
    test_random();
`ifdef SDE_EDGE_COUNT_EN
    test_edge_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
